// File: rtl/gemm_tile_ctrl.sv
// Sequencer for one output-stationary general_mac_pe computing C = A*B, with K split into Kc chunks.
// Optional: define GEMM_CTRL_CLR_ON_DONE_EN to pulse acc_clr_o alongside done_o.
module gemm_tile_ctrl #(
  parameter int SizeWidth = 8,
  parameter int AddrWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [SizeWidth-1:0] m_size_i,
  input  logic [SizeWidth-1:0] n_size_i,
  input  logic [SizeWidth-1:0] kc_size_i,
  output logic [AddrWidth-1:0] a_addr_o,
  output logic [AddrWidth-1:0] b_addr_o,
  output logic                 rd_en_o,
  output logic                 a_valid_o,
  output logic                 b_valid_o,
  output logic                 init_save_o,
  output logic                 acc_clr_o,
  output logic                 c_we_o,
  output logic [AddrWidth-1:0] c_addr_o,
  output logic                 busy_o,
  output logic                 done_o
);

`ifdef GEMM_CTRL_CLR_ON_DONE_EN
  localparam logic ClrOnDone = 1'b1;
`else
  localparam logic ClrOnDone = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } state_e;

  state_e               state_q;
  logic [SizeWidth-1:0] m_size_q, n_size_q, kc_size_q;
  logic [SizeWidth-1:0] m_q, n_q, k_q;
  logic [AddrWidth-1:0] a_base_q;
  logic [AddrWidth-1:0] c_cnt_q;
  logic                 dat_klast_q;

  logic k_last, n_last, m_last, any_zero;

  // Counters describe the address currently on a_addr_o/b_addr_o.
  assign k_last   = (k_q == kc_size_q - SizeWidth'(1));
  assign n_last   = (n_q == n_size_q - SizeWidth'(1));
  assign m_last   = (m_q == m_size_q - SizeWidth'(1));
  assign any_zero = (m_size_i == '0) || (n_size_i == '0) || (kc_size_i == '0);

  // NOTE: every register here, outputs included, is updated with <= so all
  // pipeline stages see the pre-edge values of each other.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      m_size_q    <= '0;
      n_size_q    <= '0;
      kc_size_q   <= '0;
      m_q         <= '0;
      n_q         <= '0;
      k_q         <= '0;
      a_base_q    <= '0;
      c_cnt_q     <= '0;
      dat_klast_q <= 1'b0;
      a_addr_o    <= '0;
      b_addr_o    <= '0;
      rd_en_o     <= 1'b0;
      a_valid_o   <= 1'b0;
      b_valid_o   <= 1'b0;
      init_save_o <= 1'b0;
      acc_clr_o   <= 1'b0;
      c_we_o      <= 1'b0;
      c_addr_o    <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      // Read data returns one cycle after the address; controls follow it.
      a_valid_o   <= rd_en_o;
      b_valid_o   <= rd_en_o;
      init_save_o <= rd_en_o && (k_q == '0);
      dat_klast_q <= rd_en_o && k_last;
      c_we_o      <= dat_klast_q;
      if (dat_klast_q) begin
        c_addr_o <= c_cnt_q;
        c_cnt_q  <= c_cnt_q + AddrWidth'(1);
      end
      done_o    <= 1'b0;
      acc_clr_o <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            m_size_q  <= m_size_i;
            n_size_q  <= n_size_i;
            kc_size_q <= kc_size_i;
            m_q       <= '0;
            n_q       <= '0;
            k_q       <= '0;
            a_base_q  <= '0;
            a_addr_o  <= '0;
            b_addr_o  <= '0;
            c_cnt_q   <= '0;
            if (any_zero) begin
              state_q   <= FIN;
              done_o    <= 1'b1;
              acc_clr_o <= ClrOnDone;
            end else begin
              state_q <= RUN;
              rd_en_o <= 1'b1;
              busy_o  <= 1'b1;
            end
          end
        end

        RUN: begin
          if (!k_last) begin
            k_q      <= k_q + SizeWidth'(1);
            a_addr_o <= a_addr_o + AddrWidth'(1);
            b_addr_o <= b_addr_o + AddrWidth'(1);
          end else begin
            k_q <= '0;
            if (!n_last) begin
              // Same A row again; B moves on to the next packed column.
              n_q      <= n_q + SizeWidth'(1);
              a_addr_o <= a_base_q;
              b_addr_o <= b_addr_o + AddrWidth'(1);
            end else begin
              n_q      <= '0;
              b_addr_o <= '0;
              if (!m_last) begin
                m_q      <= m_q + SizeWidth'(1);
                a_addr_o <= a_addr_o + AddrWidth'(1);
                a_base_q <= a_addr_o + AddrWidth'(1);
              end else begin
                state_q <= DRAIN;
                rd_en_o <= 1'b0;
              end
            end
          end
        end

        DRAIN: begin
          // With no data left in flight, this write is the final one.
          if (c_we_o && !a_valid_o) begin
            state_q   <= FIN;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            acc_clr_o <= ClrOnDone;
          end
        end

        FIN: state_q <= IDLE;

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gemm_tile_ctrl.sv
// Directed bench for gemm_tile_ctrl with a behavioural SRAM + MAC PE model (one element per chunk).
// Expectations depend on whether GEMM_CTRL_CLR_ON_DONE_EN is defined for the build.
module tb_gemm_tile_ctrl;
  localparam int SW  = 8;
  localparam int AW  = 16;
  localparam int WIN = 24;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic [SW-1:0] m_size_i = '0, n_size_i = '0, kc_size_i = '0;
  logic [AW-1:0] a_addr_o, b_addr_o, c_addr_o;
  logic          rd_en_o, a_valid_o, b_valid_o, init_save_o, acc_clr_o, c_we_o, busy_o, done_o;

  gemm_tile_ctrl #(.SizeWidth(SW), .AddrWidth(AW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .m_size_i    (m_size_i),
    .n_size_i    (n_size_i),
    .kc_size_i   (kc_size_i),
    .a_addr_o    (a_addr_o),
    .b_addr_o    (b_addr_o),
    .rd_en_o     (rd_en_o),
    .a_valid_o   (a_valid_o),
    .b_valid_o   (b_valid_o),
    .init_save_o (init_save_o),
    .acc_clr_o   (acc_clr_o),
    .c_we_o      (c_we_o),
    .c_addr_o    (c_addr_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  // SRAMs with one-cycle read latency feeding a MAC that init_save overwrites.
  logic signed [7:0]  a_mem [16];
  logic signed [7:0]  b_mem [16];
  logic signed [7:0]  a_rd, b_rd;
  logic signed [31:0] acc, prod;
  assign prod = a_rd * b_rd;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_rd <= '0;
      b_rd <= '0;
      acc  <= '0;
    end else begin
      if (rd_en_o) begin
        a_rd <= a_mem[a_addr_o[3:0]];
        b_rd <= b_mem[b_addr_o[3:0]];
      end
      if (acc_clr_o) acc <= '0;
      else if (a_valid_o && b_valid_o) acc <= init_save_o ? prod : acc + prod;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Per-cycle trace of one operation; cycle 0 is the cycle start_i is sampled in.
  int t_rd[WIN], t_a[WIN], t_b[WIN], t_av[WIN], t_init[WIN], t_clr[WIN];
  int t_we[WIN], t_ca[WIN], t_busy[WIN], t_done[WIN], t_c[WIN], t_any[WIN];
  int n_rd, n_we, n_done, n_busy, n_av, n_clr_conflict, n_we_late, first_done;

  task automatic run_op(input int m, input int n, input int kc, input int restart_cyc,
                        input int rst_cyc);
    n_rd = 0; n_we = 0; n_done = 0; n_busy = 0; n_av = 0;
    n_clr_conflict = 0; n_we_late = 0; first_done = -1;
    @(posedge clk_i);
    #1;
    start_i   = 1'b1;
    m_size_i  = SW'(m);
    n_size_i  = SW'(n);
    kc_size_i = SW'(kc);
    for (int c = 0; c < WIN; c++) begin
      if (c == rst_cyc) rst_ni = 1'b0;
      if (rst_cyc >= 0 && c == rst_cyc + 2) rst_ni = 1'b1;
      if (c == restart_cyc) start_i = 1'b1;
      @(negedge clk_i);
      t_rd[c]   = int'(rd_en_o);
      t_a[c]    = int'(a_addr_o);
      t_b[c]    = int'(b_addr_o);
      t_av[c]   = int'(a_valid_o & b_valid_o);
      t_init[c] = int'(init_save_o);
      t_clr[c]  = int'(acc_clr_o);
      t_we[c]   = int'(c_we_o);
      t_ca[c]   = int'(c_addr_o);
      t_busy[c] = int'(busy_o);
      t_done[c] = int'(done_o);
      t_c[c]    = int'(acc);
      t_any[c]  = int'(|{rd_en_o, a_valid_o, b_valid_o, init_save_o, acc_clr_o, c_we_o,
                         busy_o, done_o, a_addr_o, b_addr_o, c_addr_o});
      n_rd   += t_rd[c];
      n_we   += t_we[c];
      n_done += t_done[c];
      n_busy += t_busy[c];
      n_av   += t_av[c];
      if (acc_clr_o && (a_valid_o || b_valid_o || init_save_o)) n_clr_conflict++;
      if (rst_cyc >= 0 && c >= rst_cyc) n_we_late += t_we[c];
      if (done_o && first_done < 0) first_done = c;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
    end
  endtask

  initial begin
    int idx, km, kn, kk;
    int exp_c[4];
    exp_c = '{-3, 3, 19, -24};

    // Reset state
    @(negedge clk_i);
    check("rst_outputs", int'(|{rd_en_o, a_valid_o, b_valid_o, init_save_o, acc_clr_o, c_we_o,
                              busy_o, done_o, a_addr_o, b_addr_o, c_addr_o}), 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("idle_busy", int'(busy_o), 0);

    // M=N=Kc=1: single element 7 * -3
    a_mem[0] = 8'sd7;
    b_mem[0] = -8'sd3;
    run_op(1, 1, 1, -1, -1);
    check("t1_rd_c1", t_rd[1], 1);
    check("t1_a_c1", t_a[1], 0);
    check("t1_b_c1", t_b[1], 0);
    check("t1_rd_count", n_rd, 1);
    check("t1_valid_c2", t_av[2], 1);
    check("t1_init_c2", t_init[2], 1);
    check("t1_we_c3", t_we[3], 1);
    check("t1_caddr_c3", t_ca[3], 0);
    check("t1_cdata_c3", t_c[3], -21);
    check("t1_done_c4", t_done[4], 1);
    check("t1_done_count", n_done, 1);
    check("t1_busy_c0", t_busy[0], 0);
    check("t1_busy_count", n_busy, 3);
    check("t1_busy_c4", t_busy[4], 0);
    check("t1_clr_conflict", n_clr_conflict, 0);
`ifdef GEMM_CTRL_CLR_ON_DONE_EN
    check("t1_clr_c4", t_clr[4], 1);
    check("t1_c_after", t_c[5], 0);
`else
    check("t1_clr_c4", t_clr[4], 0);
    check("t1_c_after", t_c[5], -21);
`endif

    // M=2, N=2, Kc=3: A rows {1,-2,3},{4,5,-6}; B cols {2,1,-1},{-3,0,2}
    a_mem[0] = 8'sd1;  a_mem[1] = -8'sd2; a_mem[2] = 8'sd3;
    a_mem[3] = 8'sd4;  a_mem[4] = 8'sd5;  a_mem[5] = -8'sd6;
    b_mem[0] = 8'sd2;  b_mem[1] = 8'sd1;  b_mem[2] = -8'sd1;
    b_mem[3] = -8'sd3; b_mem[4] = 8'sd0;  b_mem[5] = 8'sd2;
    run_op(2, 2, 3, -1, -1);
    for (int c = 1; c <= 12; c++) begin
      idx = c - 1;
      kk  = idx % 3;
      kn  = (idx / 3) % 2;
      km  = idx / 6;
      check($sformatf("t2_rd_c%0d", c), t_rd[c], 1);
      check($sformatf("t2_a_c%0d", c), t_a[c], km * 3 + kk);
      check($sformatf("t2_b_c%0d", c), t_b[c], kn * 3 + kk);
    end
    check("t2_rd_count", n_rd, 12);
    check("t2_we_count", n_we, 4);
    for (int e = 0; e < 4; e++) begin
      check($sformatf("t2_we_c%0d", 5 + 3 * e), t_we[5 + 3 * e], 1);
      check($sformatf("t2_caddr_%0d", e), t_ca[5 + 3 * e], e);
      check($sformatf("t2_cdata_%0d", e), t_c[5 + 3 * e], exp_c[e]);
    end
    check("t2_init_c5", t_init[5], 1);
    check("t2_done_at", first_done, 15);
    check("t2_busy_count", n_busy, 14);
    check("t2_clr_conflict", n_clr_conflict, 0);

    // Kc=0 with M=N=4: immediate completion, nothing issued
    run_op(4, 4, 0, -1, -1);
    check("t3_done_at", first_done, 1);
    check("t3_rd_count", n_rd, 0);
    check("t3_we_count", n_we, 0);
    check("t3_valid_count", n_av, 0);
    check("t3_busy_count", n_busy, 0);

    // M=N=Kc=2 with a second start pulse at cycle 5
    run_op(2, 2, 2, 5, -1);
    check("t4_we_count", n_we, 4);
    check("t4_done_count", n_done, 1);
    check("t4_done_at", first_done, 11);
    check("t4_rd_count", n_rd, 8);

    // M=N=Kc=2 with reset asserted at cycle 4
    run_op(2, 2, 2, -1, 4);
    check("t5_busy_c3", t_busy[3], 1);
    check("t5_outputs_c4", t_any[4], 0);
    check("t5_we_after_rst", n_we_late, 0);
    check("t5_done_count", n_done, 0);

    // Fresh start after reset completes normally
    a_mem[0] = 8'sd7;
    b_mem[0] = -8'sd3;
    run_op(1, 1, 1, -1, -1);
    check("t6_we_c3", t_we[3], 1);
    check("t6_cdata_c3", t_c[3], -21);
    check("t6_done_at", first_done, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/gemm_tile_ctrl.md
# gemm_tile_ctrl

Sequencer for one output-stationary `general_mac_pe` performing C[M×N] = A[M×K]·B[K×N]. K is processed in chunks of NumInputs elements. The block:
- issues A/B SRAM read addresses;
- drives the PE's valid, init_save and clear controls;
- issues a C write when each output element completes.

It sits between the GEMM top-level register interface (start and sizes) and the PE/SRAM datapath.

## Interface
Parameters:
- `SizeWidth`, default 8: width of M, N and K-chunk counts.
- `AddrWidth`, default 16: SRAM address width for A, B and C.

Ports:
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: asynchronous active-low reset.
- `start_i`  in  1: start pulse; sampled only in IDLE.
- `m_size_i`  in  SizeWidth: rows M.
- `n_size_i`  in  SizeWidth: columns N.
- `kc_size_i`  in  SizeWidth: K chunks Kc (K/NumInputs).
- `a_addr_o`  out  AddrWidth: A read address.
- `b_addr_o`  out  AddrWidth: B read address.
- `rd_en_o`  out  1: A/B read enable.
- `a_valid_o`  out  1: to PE `a_valid_i`.
- `b_valid_o`  out  1: to PE `b_valid_i`.
- `init_save_o`  out  1: to PE `init_save_i`.
- `acc_clr_o`  out  1: to PE `acc_clr_i`.
- `c_we_o`  out  1: C write enable; PE `c_o` is the write data.
- `c_addr_o`  out  AddrWidth: C write address.
- `busy_o`  out  1: operation in progress.
- `done_o`  out  1: single-cycle completion pulse.

## Operation
- States: IDLE, RUN, DRAIN, FIN.
- **IDLE**
  - `start_i`=1 latches the three sizes.
  - If any size is 0: go to FIN.
  - Otherwise: go to RUN, with counters m=n=k=0.
- **RUN**, one read issued per cycle:
  - `rd_en_o`=1.
  - `a_addr_o`=m·Kc+k (A row-major, chunk-packed).
  - `b_addr_o`=n·Kc+k (B column-major, chunk-packed).
  - Loop order is k innermost, then n, then m.
  - Addresses are generated with incrementing base registers, not multipliers, and wrap modulo 2^AddrWidth.
  - After the address with m=M-1, n=N-1, k=Kc-1 is issued: go to DRAIN.
- **Read latency is 1 cycle.** A 1-stage control pipeline aligns the PE controls with returning data:
  - `a_valid_o`=`b_valid_o`=1 in the cycle after each issued address.
  - `init_save_o`=1 in that cycle when its k=0; this overwrites the accumulator.
- **C write**
  - In the cycle after the data cycle with k=Kc-1: `c_we_o`=1, `c_addr_o`=m·N+n of that element.
  - Back-to-back elements carry no bubble. The PE's init_save for the next element and `c_we_o` for the previous element coincide; `c_o` is still the old result in that cycle.
- **DRAIN**: remains until the final `c_we_o` cycle, then goes to FIN.
- **FIN**: `done_o`=1 for one cycle, then IDLE.
- `start_i` outside IDLE is ignored.
- Size inputs are don't-care except in the start cycle.

## Timing
- Reset value of every output: 0, including addresses; state is IDLE.
- Start sampled in cycle 0:
  - Addresses issued in cycles 1..T, where T=M·N·Kc.
  - Data/valid cycles are 2..T+1.
  - The last `c_we_o` is in cycle T+2.
  - `done_o` is in cycle T+3.
- `busy_o`=1 in cycles 1..T+2 (RUN and DRAIN); 0 in IDLE and FIN.
- Zero-size start: `done_o` in cycle 1, with no `rd_en_o`, valid or `c_we_o` ever asserted.
- Reset asserted mid-operation: all outputs go to 0 immediately and state returns to IDLE. No partial write completes after reset.
- `acc_clr_o` is never asserted in the same cycle as valid or `init_save_o`.

## Configuration
- `GEMM_CTRL_CLR_ON_DONE_EN` defined: `acc_clr_o`=1 in the FIN cycle (together with `done_o`), so the PE returns to `c_o`=0 after every operation, including zero-size ones.
- `GEMM_CTRL_CLR_ON_DONE_EN` undefined: `acc_clr_o` is tied to 0 and the PE keeps the last result.

## Test plan
- **M=N=Kc=1, start at cycle 0:**
  - `rd_en_o` at cycle 1 with addresses 0/0.
  - `init_save_o`+valid at cycle 2.
  - `c_we_o` at cycle 3 with `c_addr_o`=0.
  - `done_o` at cycle 4.
- **M=2, N=2, Kc=3 with random signed A/B driven into a real PE:**
  - 12 reads, then `c_we_o` at cycles 5, 8, 11, 14 with `c_addr_o`=0, 1, 2, 3.
  - Written values equal the reference dot products.
  - `done_o` at cycle 15.
- **kc_size_i=0 (M=N=4):** `done_o` at cycle 1; zero `rd_en_o` or `c_we_o` cycles; `busy_o` never high.
- **start_i pulsed again at cycle 5 during M=N=Kc=2:** ignored; exactly 4 writes; a single `done_o` at cycle 11.
- **rst_ni low at cycle 4 of an M=N=Kc=2 run:**
  - All outputs 0 the same cycle.
  - No `c_we_o` after release.
  - A new start completes normally.
- **Build with and without `GEMM_CTRL_CLR_ON_DONE_EN`, M=N=Kc=1:**
  - With the macro: `acc_clr_o`=1 coinciding with `done_o`, and PE `c_o`=0 in the next cycle.
  - Without the macro: `acc_clr_o` stays 0 and `c_o` holds the result.
